add_round_key_gen: RTL and testbench



---
 rtl/add_round_key_gen_pkg.sv | 23 ++
 rtl/add_round_key_gen_col_ctr.sv | 31 +++
 rtl/add_round_key_gen.sv | 185 ++++++++++++++++++
 tb/tb_add_round_key_gen.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/add_round_key_gen_pkg.sv
// Shared types and helpers for the AddRoundKey engine.
package ark_pkg;

    localparam int ARK_NB_DEF = 4;
    localparam int ARK_NR_DEF = 14;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD0,
        ST_RD1,
        ST_WR0,
        ST_WR1,
        ST_DONE
    } ark_state_e;

    // Key words are stored round-major, NB packed columns per round.
    function automatic logic [31:0] ark_key_addr(input logic [5:0]  n,
                                                 input logic [31:0] col,
                                                 input logic [31:0] nb);
        return ({26'd0, n} * nb) + col;
    endfunction

endpackage

// File: rtl/add_round_key_gen_col_ctr.sv
// Column counter for the AddRoundKey engine: clear, increment, last-column flag.
module ark_col_ctr
    import ark_pkg::*;
#(
    parameter int NB = ARK_NB_DEF,
    parameter int CW = $clog2(NB)
) (
    input  logic          ap_clk,
    input  logic          ap_rst_n,
    input  logic          i_clr,
    input  logic          i_inc,
    output logic [CW-1:0] o_col,
    output logic          o_last
);

    localparam logic [CW-1:0] LAST_COL = CW'(NB - 1);

    logic [CW-1:0] r_col;

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n || i_clr) begin
            r_col <= '0;
        end else if (i_inc) begin
            r_col <= r_col + 1'b1;
        end
    end

    assign o_col  = r_col;
    assign o_last = (r_col == LAST_COL);

endmodule

// File: rtl/add_round_key_gen.sv
// AddRoundKey engine: XORs one packed-column round key into the external state RAM.
// Optional range check on the round index is enabled by defining ARK_RANGE_CHK_EN.
//
// state   | meaning
// IDLE    | waiting for ap_start
// RD0     | read rows 0/1 of col, fetch key word
// RD1     | capture rows 0/1 and key, read rows 2/3
// WR0     | write rows 0/1, capture rows 2/3
// WR1     | write rows 2/3, advance or finish
// DONE    | one-cycle ap_done/ap_ready pulse
module add_round_key_gen
    import ark_pkg::*;
#(
    parameter int NB  = ARK_NB_DEF,
    parameter int NR  = ARK_NR_DEF,
    parameter int DW  = 32,
    parameter int SAW = $clog2(4 * NB),
    parameter int KAW = $clog2((NR + 1) * NB)
) (
    input  logic           ap_clk,
    input  logic           ap_rst_n,
    input  logic           ap_start,
    output logic           ap_done,
    output logic           ap_idle,
    output logic           ap_ready,
    input  logic [5:0]     n,
    output logic           err,
    output logic [SAW-1:0] statemt_address0,
    output logic [SAW-1:0] statemt_address1,
    output logic           statemt_ce0,
    output logic           statemt_ce1,
    output logic           statemt_we0,
    output logic           statemt_we1,
    output logic [DW-1:0]  statemt_d0,
    output logic [DW-1:0]  statemt_d1,
    input  logic [DW-1:0]  statemt_q0,
    input  logic [DW-1:0]  statemt_q1,
    output logic [KAW-1:0] key_address,
    output logic           key_ce,
    input  logic [31:0]    key_q
);

    localparam int CW = $clog2(NB);

    ark_state_e    r_state, w_state_nxt;
    logic [5:0]    r_n;
    logic [DW-1:0] r_q0, r_q1;
    logic [31:0]   r_key;
    logic [CW-1:0] w_col;
    logic          w_last;
    logic          w_accept;
    logic          w_rng_bad;

    assign w_accept = (r_state == ST_IDLE) && ap_start;

`ifdef ARK_RANGE_CHK_EN
    localparam logic [5:0] NR_MAX = 6'(NR);
    logic r_err;

    assign w_rng_bad = (n > NR_MAX);

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_err <= 1'b0;
        end else if (w_accept) begin
            r_err <= w_rng_bad;
        end
    end

    assign err = r_err;
`else
    assign w_rng_bad = 1'b0;
    assign err       = 1'b0;
`endif

    ark_col_ctr #(.NB(NB), .CW(CW)) u_col_ctr (
        .ap_clk   (ap_clk),
        .ap_rst_n (ap_rst_n),
        .i_clr    (w_accept),
        .i_inc    ((r_state == ST_WR1) && !w_last),
        .o_col    (w_col),
        .o_last   (w_last)
    );

    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Rows 0/1 land on q in RD1, rows 2/3 in WR0; the same pair of registers serves both.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_n   <= '0;
            r_q0  <= '0;
            r_q1  <= '0;
            r_key <= '0;
        end else begin
            if (w_accept) begin
                r_n <= n;
            end
            if (r_state == ST_RD1 || r_state == ST_WR0) begin
                r_q0 <= statemt_q0;
                r_q1 <= statemt_q1;
            end
            if (r_state == ST_RD1) begin
                r_key <= key_q;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: if (ap_start) w_state_nxt = w_rng_bad ? ST_DONE : ST_RD0;
            ST_RD0:  w_state_nxt = ST_RD1;
            ST_RD1:  w_state_nxt = ST_WR0;
            ST_WR0:  w_state_nxt = ST_WR1;
            ST_WR1:  w_state_nxt = w_last ? ST_DONE : ST_RD0;
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Memory strobes are gated by reset so an in-flight write is dropped in the reset cycle.
    always_comb begin
        statemt_address0 = '0;
        statemt_address1 = '0;
        statemt_ce0      = 1'b0;
        statemt_ce1      = 1'b0;
        statemt_we0      = 1'b0;
        statemt_we1      = 1'b0;
        statemt_d0       = '0;
        statemt_d1       = '0;
        key_address      = '0;
        key_ce           = 1'b0;
        ap_done          = 1'b0;
        if (ap_rst_n) begin
            case (r_state)
                ST_RD0: begin
                    statemt_ce0      = 1'b1;
                    statemt_ce1      = 1'b1;
                    statemt_address0 = SAW'({w_col, 2'd0});
                    statemt_address1 = SAW'({w_col, 2'd1});
                    key_ce           = 1'b1;
                    key_address      = KAW'(ark_key_addr(r_n, 32'(w_col), 32'(NB)));
                end
                ST_RD1: begin
                    statemt_ce0      = 1'b1;
                    statemt_ce1      = 1'b1;
                    statemt_address0 = SAW'({w_col, 2'd2});
                    statemt_address1 = SAW'({w_col, 2'd3});
                end
                ST_WR0: begin
                    statemt_ce0      = 1'b1;
                    statemt_ce1      = 1'b1;
                    statemt_we0      = 1'b1;
                    statemt_we1      = 1'b1;
                    statemt_address0 = SAW'({w_col, 2'd0});
                    statemt_address1 = SAW'({w_col, 2'd1});
                    statemt_d0       = r_q0 ^ DW'(r_key[7:0]);
                    statemt_d1       = r_q1 ^ DW'(r_key[15:8]);
                end
                ST_WR1: begin
                    statemt_ce0      = 1'b1;
                    statemt_ce1      = 1'b1;
                    statemt_we0      = 1'b1;
                    statemt_we1      = 1'b1;
                    statemt_address0 = SAW'({w_col, 2'd2});
                    statemt_address1 = SAW'({w_col, 2'd3});
                    statemt_d0       = r_q0 ^ DW'(r_key[23:16]);
                    statemt_d1       = r_q1 ^ DW'(r_key[31:24]);
                end
                ST_DONE: ap_done = 1'b1;
                default: ;
            endcase
        end
    end

    assign ap_ready = ap_done;
    assign ap_idle  = !ap_rst_n || (r_state == ST_IDLE);

endmodule

// File: tb/tb_add_round_key_gen.sv
// Bench for add_round_key_gen: NB=4 and NB=8 instances against behavioural RAM/key models.
module tb_add_round_key_gen;

    localparam int NR = 14;

    logic ap_clk = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic             ap_rst_n;
    logic [1:0]       start, done, idle, ready, err, kce;
    logic [1:0]       ce0, ce1, we0, we1;
    logic [1:0][5:0]  nin;
    logic [1:0][31:0] d0, d1, q0, q1, kq;
    logic [3:0]       a0_4, a1_4;
    logic [4:0]       a0_8, a1_8;
    logic [5:0]       ka_4;
    logic [6:0]       ka_8;

    logic [31:0] smem4 [16];
    logic [31:0] smem8 [32];
    logic [31:0] kmem4 [64];
    logic [31:0] kmem8 [128];
    logic [31:0] exp_m [32];
    int          kseq0 [$];
    int          kseq1 [$];
    int          acc0, acc1;
    int          n_chk, n_pass;

    add_round_key_gen #(.NB(4), .NR(NR)) u_dut4 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(start[0]), .ap_done(done[0]),
        .ap_idle(idle[0]), .ap_ready(ready[0]), .n(nin[0]), .err(err[0]),
        .statemt_address0(a0_4), .statemt_address1(a1_4),
        .statemt_ce0(ce0[0]), .statemt_ce1(ce1[0]), .statemt_we0(we0[0]), .statemt_we1(we1[0]),
        .statemt_d0(d0[0]), .statemt_d1(d1[0]), .statemt_q0(q0[0]), .statemt_q1(q1[0]),
        .key_address(ka_4), .key_ce(kce[0]), .key_q(kq[0])
    );

    add_round_key_gen #(.NB(8), .NR(NR)) u_dut8 (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(start[1]), .ap_done(done[1]),
        .ap_idle(idle[1]), .ap_ready(ready[1]), .n(nin[1]), .err(err[1]),
        .statemt_address0(a0_8), .statemt_address1(a1_8),
        .statemt_ce0(ce0[1]), .statemt_ce1(ce1[1]), .statemt_we0(we0[1]), .statemt_we1(we1[1]),
        .statemt_d0(d0[1]), .statemt_d1(d1[1]), .statemt_q0(q0[1]), .statemt_q1(q1[1]),
        .key_address(ka_8), .key_ce(kce[1]), .key_q(kq[1])
    );

    always @(posedge ap_clk) begin
        if (ce0[0]) begin
            if (we0[0]) smem4[a0_4] <= d0[0];
            q0[0] <= smem4[a0_4];
        end
        if (ce1[0]) begin
            if (we1[0]) smem4[a1_4] <= d1[0];
            q1[0] <= smem4[a1_4];
        end
        if (kce[0]) begin
            kq[0] <= kmem4[ka_4];
            kseq0.push_back(int'(ka_4));
        end
        if (ce0[0] || ce1[0] || kce[0]) acc0 <= acc0 + 1;
        if (ce0[1]) begin
            if (we0[1]) smem8[a0_8] <= d0[1];
            q0[1] <= smem8[a0_8];
        end
        if (ce1[1]) begin
            if (we1[1]) smem8[a1_8] <= d1[1];
            q1[1] <= smem8[a1_8];
        end
        if (kce[1]) begin
            kq[1] <= kmem8[ka_8];
            kseq1.push_back(int'(ka_8));
        end
        if (ce0[1] || ce1[1] || kce[1]) acc1 <= acc1 + 1;
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int nb_of(input bit s);
        return s ? 8 : 4;
    endfunction

    function automatic logic [31:0] rd_mem(input bit s, input int i);
        return s ? smem8[i] : smem4[i];
    endfunction

    task automatic wr_mem(input bit s, input int i, input logic [31:0] v);
        if (s) smem8[i] = v;
        else   smem4[i] = v;
    endtask

    function automatic logic [31:0] rd_key(input bit s, input int i);
        return s ? kmem8[i] : kmem4[i];
    endfunction

    function automatic int ksz(input bit s);
        return s ? kseq1.size() : kseq0.size();
    endfunction

    function automatic int kat(input bit s, input int i);
        return s ? kseq1[i] : kseq0[i];
    endfunction

    task automatic snap(input bit s);
        for (int i = 0; i < 4 * nb_of(s); i++) exp_m[i] = rd_mem(s, i);
    endtask

    // Reference: every element of column c gets the matching key byte of word n*NB+c.
    task automatic model_op(input bit s, input int nv, input int ncols);
        logic [31:0] w;
        int          m;
        m = s ? 128 : 64;
        for (int c = 0; c < ncols; c++) begin
            w = rd_key(s, (nv * nb_of(s) + c) % m);
            for (int r = 0; r < 4; r++) exp_m[4 * c + r] = exp_m[4 * c + r] ^ {24'd0, w[8 * r +: 8]};
        end
    endtask

    task automatic check_mem(input bit s, input string tag);
        for (int i = 0; i < 4 * nb_of(s); i++) check_val(tag, rd_mem(s, i), exp_m[i]);
    endtask

    task automatic check_keys(input bit s, input int nv, input int kb);
        int m;
        m = s ? 128 : 64;
        check_val("key_count", 32'(ksz(s) - kb), 32'(nb_of(s)));
        for (int c = 0; c < nb_of(s); c++) begin
            if (kb + c < ksz(s)) check_val("key_addr", 32'(kat(s, kb + c)), 32'((nv * nb_of(s) + c) % m));
        end
    endtask

    task automatic run_op(input bit s, input logic [5:0] nv, output int lat, output int kb);
        kb = ksz(s);
        @(negedge ap_clk);
        start[s] = 1'b1;
        nin[s]   = nv;
        lat      = 0;
        while (lat < 200) begin
            @(posedge ap_clk);
            #1;
            lat++;
            if (lat == 1) start[s] = 1'b0;
            if (done[s]) break;
        end
        check_val("done_seen", 32'(done[s]), 32'd1);
        check_val("ready_eq_done", 32'(ready[s]), 32'(done[s]));
        @(posedge ap_clk);
        #1;
        check_val("done_pulse", 32'(done[s]), 32'd0);
        check_val("idle_after", 32'(idle[s]), 32'd1);
    endtask

    initial begin
        int          lat, kb, nv, nd, e1, e2, base;
        bit          s;
        n_chk    = 0;
        n_pass   = 0;
        acc0     = 0;
        acc1     = 0;
        start    = '0;
        nin      = '0;
        ap_rst_n = 1'b0;
        for (int i = 0; i < 64; i++)  kmem4[i] = $urandom;
        for (int i = 0; i < 128; i++) kmem8[i] = $urandom;
        for (int i = 0; i < 16; i++)  smem4[i] = '0;
        for (int i = 0; i < 32; i++)  smem8[i] = '0;

        repeat (3) @(posedge ap_clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            check_val("rst_idle", 32'(idle[k]), 32'd1);
            check_val("rst_done", 32'(done[k] | ready[k]), 32'd0);
            check_val("rst_err", 32'(err[k]), 32'd0);
            check_val("rst_ce_we", 32'({ce0[k], ce1[k], we0[k], we1[k], kce[k]}), 32'd0);
            check_val("rst_data", d0[k] | d1[k], 32'd0);
        end
        check_val("rst_addr", 32'({a0_4, a1_4, a0_8, a1_8, ka_4, ka_8}), 32'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        @(posedge ap_clk);
        #1;
        check_val("idle_post_rst", 32'({idle[1], idle[0]}), 32'd3);

        // state[i]=i with matching key bytes cancels to zero
        for (int i = 0; i < 16; i++) wr_mem(0, i, 32'(i));
        for (int c = 0; c < 4; c++)  kmem4[c] = 32'h03020100 + 32'h04040404 * 32'(c);
        snap(0);
        model_op(0, 0, 4);
        run_op(0, 6'd0, lat, kb);
        check_val("lat_nb4", 32'(lat), 32'd17);
        check_mem(0, "xor_self");
        check_val("elem9_zero", smem4[9], 32'd0);
        check_keys(0, 0, kb);

        // NB=8, n=3: 0xA5 ^ 0xFF = 0x5A everywhere
        for (int i = 0; i < 32; i++) wr_mem(1, i, 32'hA5);
        for (int c = 0; c < 8; c++)  kmem8[24 + c] = 32'hFFFFFFFF;
        snap(1);
        model_op(1, 3, 8);
        run_op(1, 6'd3, lat, kb);
        check_val("lat_nb8", 32'(lat), 32'd33);
        check_mem(1, "xor_a5");
        check_val("elem31_5a", smem8[31], 32'h5A);
        check_keys(1, 3, kb);

        // upper 24 bits must survive
        for (int i = 0; i < 16; i++) wr_mem(0, i, {24'hDEAD00, 8'($urandom)});
        nv = $urandom_range(0, NR);
        snap(0);
        model_op(0, nv, 4);
        run_op(0, 6'(nv), lat, kb);
        check_mem(0, "upper_model");
        for (int i = 0; i < 16; i += 5) check_val("upper_bits", 32'(smem4[i][31:8]), 32'hDEAD00);

        // out-of-range round index
        for (int i = 0; i < 16; i++) wr_mem(0, i, $urandom);
        snap(0);
`ifdef ARK_RANGE_CHK_EN
        base = acc0;
        run_op(0, 6'd15, lat, kb);
        check_val("rej_lat", 32'(lat), 32'd1);
        check_val("rej_no_access", 32'(acc0 - base), 32'd0);
        check_val("rej_err", 32'(err[0]), 32'd1);
        repeat (3) @(posedge ap_clk);
        #1;
        check_val("err_sticky", 32'(err[0]), 32'd1);
        check_mem(0, "rej_mem");
        model_op(0, 1, 4);
        run_op(0, 6'd1, lat, kb);
        check_val("err_cleared", 32'(err[0]), 32'd0);
        check_mem(0, "after_rej");
`else
        base = acc0;
        model_op(0, 15, 4);
        run_op(0, 6'd15, lat, kb);
        check_val("n15_lat", 32'(lat), 32'd17);
        check_val("n15_err", 32'(err[0]), 32'd0);
        check_val("n15_access", 32'(acc0 - base), 32'd16);
        check_mem(0, "n15_mem");
        check_keys(0, 15, kb);
`endif

        // reset during WR0 of column 2
        for (int i = 0; i < 16; i++) wr_mem(0, i, $urandom);
        nv = $urandom_range(0, NR);
        snap(0);
        model_op(0, nv, 2);
        @(negedge ap_clk);
        start[0] = 1'b1;
        nin[0]   = 6'(nv);
        for (int e = 1; e <= 11; e++) begin
            @(posedge ap_clk);
            #1;
            if (e == 1) start[0] = 1'b0;
        end
        check_val("wr0_col2_we", 32'({we0[0], we1[0], a0_4}), 32'h38);
        ap_rst_n = 1'b0;
        @(posedge ap_clk);
        #1;
        ap_rst_n = 1'b1;
        check_val("midrst_idle", 32'(idle[0]), 32'd1);
        repeat (3) @(posedge ap_clk);
        #1;
        check_val("midrst_still_idle", 32'(idle[0]), 32'd1);
        check_mem(0, "midrst_mem");

        // start held high across completions
        @(negedge ap_clk);
        start[0] = 1'b1;
        nin[0]   = 6'($urandom_range(0, NR));
        nd = 0;
        e1 = 0;
        e2 = 0;
        for (int e = 1; e <= 40; e++) begin
            @(posedge ap_clk);
            #1;
            if (done[0]) begin
                nd++;
                if (nd == 1) e1 = e;
                else if (nd == 2) e2 = e;
            end
        end
        start[0] = 1'b0;
        check_val("held_count", 32'(nd), 32'd2);
        check_val("held_first", 32'(e1), 32'd17);
        check_val("held_second", 32'(e2), 32'd35);
        repeat (30) @(posedge ap_clk);
        #1;
        check_val("held_drain_idle", 32'(idle[0]), 32'd1);

        // randomized operations on both instances
        for (int t = 0; t < 8; t++) begin
            s  = 1'($urandom_range(0, 1));
            nv = $urandom_range(0, NR);
            for (int i = 0; i < 4 * nb_of(s); i++) wr_mem(s, i, $urandom);
            snap(s);
            model_op(s, nv, nb_of(s));
            run_op(s, 6'(nv), lat, kb);
            check_val("rand_lat", 32'(lat), 32'(4 * nb_of(s) + 1));
            check_val("rand_err", 32'(err[s]), 32'd0);
            check_mem(s, "rand_mem");
            check_keys(s, nv, kb);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
